soc_bus_initiator: RTL and testbench
====================================

SOC_BUS_INITIATOR -- requirements
Module: soc_bus_initiator

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles req is held waiting for bus.valid; 0 disables the timeout.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 res  input  1  reset, asynchronous, active-low (res=0 resets).
REQ-004 bus  SoC_MemBus.Master  -  drives req/addr/write_en/write_data/byte_en, samples valid/read_data.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready.
REQ-007 cmd_addr  input  32  target address.
REQ-008 cmd_write  input  1  1=write, 0=read.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_byte_en  input  4  byte enables.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-013 rsp_data  output  32  read data (writes: 0).
REQ-014 rsp_err  output  1  1 = transaction timed out.
REQ-015 busy  output  1  1 in any state other than IDLE.

Function
REQ-016 FSM states SHALL be IDLE, REQ, RESP; all outputs derive from registered state and latched fields.
REQ-017 IDLE: cmd_ready=1; on cmd_valid, latch cmd_addr/cmd_write/cmd_wdata/cmd_byte_en, clear timeout counter, go to REQ.
REQ-018 REQ: bus.req=1; bus.addr, bus.write_en, bus.write_data, bus.byte_en SHALL equal latched fields and stay constant throughout REQ.
REQ-019 Outside REQ, bus.req, bus.addr, bus.write_en, bus.write_data and bus.byte_en SHALL all be 0.
REQ-020 REQ, bus.valid=1 sampled: latch rsp_data=bus.read_data on reads (0 on writes), rsp_err=0, go to RESP; req drops the following cycle.
REQ-021 REQ, no valid: counter increments; when counter==TIMEOUT-1 (TIMEOUT>0), go to RESP with rsp_err=1, rsp_data=0.
REQ-022 bus.valid and timeout in the same cycle: valid wins, rsp_err=0.
REQ-023 RESP: rsp_valid=1, rsp_data/rsp_err held stable; on rsp_ready go to IDLE; cmd_ready=0.
REQ-024 Each transaction SHALL have at least one cycle with bus.req=0 (RESP) before the next req, so the responder clears its latched state; back-to-back same-address accesses SHALL not reuse a stale valid.
REQ-025 Minimum throughput: one transaction per (responder latency + 3) cycles; cmd accepted cycle N -> bus.req=1 from N+1.
REQ-026 Counter width SHALL be $clog2(TIMEOUT+1) bits minimum; SHALL not wrap inside REQ.
REQ-027 byte_en=0000 writes and reads SHALL still be issued on the bus unchanged.
REQ-028 cmd_valid while busy SHALL be ignored (no latch, no side effect).

Reset
REQ-029 res=0 SHALL asynchronously force IDLE, bus.req=0 and all bus outputs 0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, counter 0, cmd_ready=1 after release.
REQ-030 Reset during REQ or RESP SHALL abort the transaction without a response; first command after release is handled normally.

Verification
REQ-031 Read: cmd addr=0x0000_0010 read, responder LATENCY=1 returns 0xDEADBEEF -> req stable until valid, rsp_valid with rsp_data=0xDEADBEEF, rsp_err=0, req=0 next cycle.
REQ-032 Write: addr=0x20, wdata=0x12345678, byte_en=0101 -> bus fields equal these for whole REQ, rsp_data=0, rsp_err=0.
REQ-033 Timeout: TIMEOUT=4, responder never valid -> req high exactly 4 cycles, rsp_err=1, rsp_data=0.
REQ-034 Back-to-back reads same addr 0x30, rsp_ready tied 1 -> req low >=1 cycle between, two distinct responses, each after full responder latency.
REQ-035 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, cmd_ready=0, new cmd_valid ignored.
REQ-036 Async reset mid-REQ -> bus.req falls without clock edge, no rsp_valid, next read completes correctly.

Source files
------------

// File: rtl/soc_bus_initiator_if.sv
// SoC memory bus between one initiator (master) and one responder (slave).
// The initiator drives the request fields; the responder returns valid/read_data.
interface soc_bus_initiator_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              write_en;
  logic [DATA_W-1:0] write_data;
  logic [BE_W-1:0]   byte_en;
  logic              valid;
  logic [DATA_W-1:0] read_data;

  modport master (
    output req, addr, write_en, write_data, byte_en,
    input  valid, read_data
  );

  modport slave (
    input  req, addr, write_en, write_data, byte_en,
    output valid, read_data
  );
endinterface

// File: rtl/soc_bus_initiator.sv
// Single-outstanding bus initiator: takes one command, holds it on the bus until
// the responder answers or a timeout expires, then presents one response.
module soc_bus_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      res,
  soc_bus_initiator_if.master       bus,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [31:0]               cmd_addr,
  input  logic                      cmd_write,
  input  logic [31:0]               cmd_wdata,
  input  logic [3:0]                cmd_byte_en,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_data,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned CNT_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   byte_en;
  } cmd_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] rsp_data_d;
  logic              rsp_err_d;
  logic              req_d;

  // Next-state, latched command and response capture
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    rsp_data_d = rsp_data;
    rsp_err_d  = rsp_err;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_d.addr    = cmd_addr;
          cmd_d.write   = cmd_write;
          cmd_d.wdata   = cmd_wdata;
          cmd_d.byte_en = cmd_byte_en;
          cnt_d         = '0;
          state_d       = ST_REQ;
        end
      end
      ST_REQ: begin
        // A response in the final allowed cycle beats the timeout
        if (bus.valid) begin
          rsp_data_d = cmd_q.write ? '0 : bus.read_data;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    req_d = (state_d == ST_REQ);
  end

  // State plus registered outputs, all derived from the next state
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      cmd_q          <= '0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      rsp_valid      <= 1'b0;
      cmd_ready      <= 1'b1;
      busy           <= 1'b0;
      bus.req        <= 1'b0;
      bus.addr       <= '0;
      bus.write_en   <= 1'b0;
      bus.write_data <= '0;
      bus.byte_en    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cmd_q          <= cmd_d;
      rsp_data       <= rsp_data_d;
      rsp_err        <= rsp_err_d;
      rsp_valid      <= (state_d == ST_RESP);
      cmd_ready      <= (state_d == ST_IDLE);
      busy           <= (state_d != ST_IDLE);
      bus.req        <= req_d;
      bus.addr       <= req_d ? cmd_d.addr    : '0;
      bus.write_en   <= req_d ? cmd_d.write   : 1'b0;
      bus.write_data <= req_d ? cmd_d.wdata   : '0;
      bus.byte_en    <= req_d ? cmd_d.byte_en : '0;
    end
  end

endmodule

// File: tb/tb_soc_bus_initiator.sv
// Bench for soc_bus_initiator: random commands, behavioural responder and a
// queue-based scoreboard checked by an independent monitor.
module tb_soc_bus_initiator;

  localparam int TO = 4;

  logic        clk;
  logic        res;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_byte_en;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  soc_bus_initiator_if bus ();

  soc_bus_initiator #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .res         (res),
    .bus         (bus),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_write   (cmd_write),
    .cmd_wdata   (cmd_wdata),
    .cmd_byte_en (cmd_byte_en),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] data;
    logic        err;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_seq = 0;

  // Responder configuration (latency 0 = never answers)
  int          lat_cfg = 0;
  int          r_cnt = 0;
  int          r_seq = 0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;

  function automatic logic [31:0] fdata(input logic [31:0] a, input int s);
    return (a * 32'h9E37_79B1) ^ (32'(s) << 20) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Responder: answers in the lat_cfg-th cycle of a request, junk data otherwise
  always @(negedge clk) begin
    if (bus.req) begin
      r_cnt = r_cnt + 1;
      if (lat_cfg != 0 && r_cnt == lat_cfg) begin
        bus.valid     = 1'b1;
        bus.read_data = ovr_en ? ovr_data : fdata(bus.addr, r_seq);
        r_seq         = r_seq + 1;
      end else begin
        bus.valid     = 1'b0;
        bus.read_data = $urandom;
      end
    end else begin
      r_cnt         = 0;
      bus.valid     = 1'b0;
      bus.read_data = $urandom;
    end
  end

  // Monitor: bus fields, handshake invariants, response scoreboard
  int          req_cnt = 0;
  logic        prev_rv = 1'b0;
  logic        prev_rr = 1'b0;
  logic [31:0] prev_d = 32'h0;
  logic        prev_e = 1'b0;

  always @(negedge clk) begin
    if (!res) begin
      req_cnt = 0;
      prev_rv = 1'b0;
      prev_rr = 1'b0;
    end else begin
      if (bus.req) begin
        if (exp_q.size() == 0) begin
          chk("req_without_cmd", 128'(1), 128'(0));
        end else begin
          chk("bus_fields", 128'({bus.addr, bus.write_en, bus.write_data, bus.byte_en}),
              128'({exp_q[0].addr, exp_q[0].wr, exp_q[0].wdata, exp_q[0].be}));
        end
        req_cnt = req_cnt + 1;
      end else begin
        chk("bus_idle_zero", 128'({bus.addr, bus.write_en, bus.write_data, bus.byte_en}), 128'(0));
      end
      chk("cmd_ready_busy", 128'({cmd_ready, busy}),
          128'({!(bus.req || rsp_valid), (bus.req || rsp_valid)}));
      if (prev_rv && !prev_rr) begin
        chk("rsp_stable", 128'({rsp_valid, rsp_data, rsp_err}), 128'({1'b1, prev_d, prev_e}));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_without_cmd", 128'(1), 128'(0));
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_data", 128'(rsp_data), 128'(e.data));
          chk("rsp_err", 128'(rsp_err), 128'(e.err));
          chk("req_cycles", 128'(req_cnt), 128'(e.cycles));
        end
        req_cnt = 0;
      end
      prev_rv = rsp_valid;
      prev_rr = rsp_ready;
      prev_d  = rsp_data;
      prev_e  = rsp_err;
    end
  end

  // Reference expectation for one command under a given responder latency
  function automatic exp_t model(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                                 input logic [3:0] be, input int lat);
    exp_t e;
    e.addr = a; e.wr = wr; e.wdata = wd; e.be = be;
    if (lat >= 1 && lat <= TO) begin
      e.err    = 1'b0;
      e.cycles = lat;
      e.data   = wr ? 32'h0 : (ovr_en ? ovr_data : fdata(a, model_seq));
      model_seq++;
    end else begin
      e.err    = 1'b1;
      e.cycles = TO;
      e.data   = 32'h0;
    end
    return e;
  endfunction

  // Issue one command (called at posedge+1 with the DUT idle) and wait for its response
  task automatic do_txn(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input logic [3:0] be, input int lat, input int bp,
                        input bit junk, input bit rdy1);
    int  bp_left;
    int  n;
    bit  done;
    lat_cfg     = lat;
    exp_q.push_back(model(a, wr, wd, be, lat));
    cmd_valid   = 1'b1;
    cmd_addr    = a;
    cmd_write   = wr;
    cmd_wdata   = wd;
    cmd_byte_en = be;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("accept_to_req", 128'({bus.req, busy, cmd_ready}), 128'(3'b110));
    @(posedge clk); #1;
    bp_left = bp;
    done    = 1'b0;
    n       = 0;
    while (!done && n < 60) begin
      rsp_ready = (bp_left > 0) ? 1'b0 : (rdy1 ? 1'b1 : ($urandom_range(0, 3) != 0));
      cmd_valid = junk && !rsp_ready;
      if (cmd_valid) begin
        cmd_addr    = $urandom;
        cmd_write   = 1'($urandom_range(0, 1));
        cmd_wdata   = $urandom;
        cmd_byte_en = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      if (rsp_valid && bp_left > 0) bp_left--;
      done = rsp_valid && rsp_ready;
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    if (!done) chk("rsp_timeout", 128'(0), 128'(1));
    chk("back_to_idle", 128'({cmd_ready, busy, rsp_valid}), 128'(3'b100));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    res           = 1'b0;
    cmd_valid     = 1'b0;
    cmd_addr      = 32'h0;
    cmd_write     = 1'b0;
    cmd_wdata     = 32'h0;
    cmd_byte_en   = 4'h0;
    rsp_ready     = 1'b0;
    bus.valid     = 1'b0;
    bus.read_data = 32'h0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", 128'({bus.req, rsp_valid, rsp_data, rsp_err, busy}), 128'(0));
    chk("reset_bus", 128'({bus.addr, bus.write_en, bus.write_data, bus.byte_en}), 128'(0));
    @(posedge clk); #1;
    res = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 128'(cmd_ready), 128'(1));
    @(posedge clk); #1;

    // Directed read returning a fixed word
    ovr_en   = 1'b1;
    ovr_data = 32'hDEAD_BEEF;
    do_txn(32'h0000_0010, 1'b0, 32'h0, 4'hF, 1, 0, 1'b0, 1'b0);
    ovr_en   = 1'b0;

    // Directed write, partial byte enables
    do_txn(32'h0000_0020, 1'b1, 32'h1234_5678, 4'b0101, 2, 0, 1'b0, 1'b0);

    // Timeout boundaries: never, valid in the last cycle, one cycle too late
    do_txn(32'h0000_0040, 1'b0, 32'h0, 4'hF, 0, 0, 1'b0, 1'b0);
    do_txn(32'h0000_0044, 1'b0, 32'h0, 4'hF, TO, 0, 1'b0, 1'b0);
    do_txn(32'h0000_0048, 1'b1, 32'hCAFE_F00D, 4'hF, TO + 1, 0, 1'b0, 1'b0);

    // Back-to-back reads to one address with rsp_ready held high
    do_txn(32'h0000_0030, 1'b0, 32'h0, 4'hF, 2, 0, 1'b0, 1'b1);
    do_txn(32'h0000_0030, 1'b0, 32'h0, 4'hF, 2, 0, 1'b0, 1'b1);

    // Zero byte enables still go out on the bus
    do_txn(32'h0000_0050, 1'b1, 32'hA5A5_5A5A, 4'b0000, 1, 0, 1'b0, 1'b0);
    do_txn(32'h0000_0054, 1'b0, 32'h0, 4'b0000, 3, 0, 1'b0, 1'b0);

    // Response backpressure with new commands offered while busy
    do_txn(32'h0000_0060, 1'b0, 32'h0, 4'hF, 2, 5, 1'b1, 1'b0);

    // Asynchronous reset while the request is outstanding
    lat_cfg     = 3;
    exp_q.push_back(model(32'h0000_0070, 1'b0, 32'h0, 4'hF, 0));
    cmd_valid   = 1'b1;
    cmd_addr    = 32'h0000_0070;
    cmd_write   = 1'b0;
    cmd_wdata   = 32'h0;
    cmd_byte_en = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_req_high", 128'(bus.req), 128'(1));
    #2;
    res = 1'b0;
    #1;
    chk("async_reset", 128'({bus.req, rsp_valid, busy, bus.addr}), 128'(0));
    exp_q.delete();
    @(negedge clk);
    chk("abort_no_rsp", 128'(rsp_valid), 128'(0));
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    do_txn(32'h0000_0070, 1'b0, 32'h0, 4'hF, 2, 0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'h0000_0030 : ($urandom & 32'hFFFF_FFFC);
      do_txn(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, TO + 1), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
